// File: rtl/rx_serial_7o1_pkg.sv
// Shared definitions for the 7O1 serial receiver: state encoding, frame
// sizes and the odd-parity check used when a frame is delivered.
package rx_serial_pkg;

  // Receiver states; the 4-bit encodings are visible on the debug port
  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    START   = 4'd1,
    RECEBE  = 4'd2,
    STOP    = 4'd3,
    FINAL   = 4'd4
  } estado_t;

  // Data bits per frame and bits shifted in after the start bit (data + parity)
  localparam int N_DADOS    = 7;
  localparam int N_AMOSTRAS = 8;

  // Odd parity: the XOR over data and parity must be 1, so a 0 is an error
  function automatic logic erro_paridade_impar(input logic [N_AMOSTRAS-1:0] palavra);
    return ~(^palavra);
  endfunction

endpackage

// File: rtl/rx_serial_7o1_uc.sv
// Control unit of the 7O1 receiver: state machine, bit index and the
// decode of the half-bit and full-bit ticks from the shared counter.
module rx_serial_7o1_uc
  import rx_serial_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_s,
  input  logic [CNT_W-1:0] contagem,
  output logic             zera_cnt,
  output logic             desloca,
  output logic             amostra_stop,
  output estado_t          estado
);

  localparam logic [CNT_W-1:0] FIM_MEIO = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       ULTIMO   = 3'(N_AMOSTRAS - 1);

  estado_t    prox;
  logic [2:0] indice;
  logic       tick_meio;
  logic       tick_bit;

  assign tick_meio = (contagem == FIM_MEIO);
  assign tick_bit  = (contagem == FIM_BIT);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

  // Bit index: restarted while checking the start bit, advanced on each sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice <= '0;
    end else if (estado == START) begin
      indice <= '0;
    end else if (desloca) begin
      indice <= indice + 3'd1;
    end
  end

  // Next-state logic and counter/sampling strobes
  always_comb begin
    prox         = estado;
    zera_cnt     = 1'b0;
    desloca      = 1'b0;
    amostra_stop = 1'b0;
    unique case (estado)
      INICIAL: begin
        zera_cnt = 1'b1;
        if (!rx_s) begin
          prox = START;
        end
      end
      START: begin
        if (tick_meio) begin
          zera_cnt = 1'b1;
          prox     = rx_s ? INICIAL : RECEBE;
        end
      end
      RECEBE: begin
        if (tick_bit) begin
          zera_cnt = 1'b1;
          desloca  = 1'b1;
          if (indice == ULTIMO) begin
            prox = STOP;
          end
        end
      end
      STOP: begin
        if (tick_bit) begin
          zera_cnt     = 1'b1;
          amostra_stop = 1'b1;
          prox         = FINAL;
        end
      end
      FINAL: begin
        zera_cnt = 1'b1;
        prox     = INICIAL;
      end
      default: begin
        zera_cnt = 1'b1;
        prox     = INICIAL;
      end
    endcase
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver (start, 7 data LSB first, odd parity,
// stop). Holds the datapath: input synchronizer, bit-period counter,
// shift register and output registers; sequencing lives in rx_serial_7o1_uc.
// Optional macro RX_DEBUG_EN exposes the state (db_estado) and the
// synchronized line (db_rx_s).
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dado_serial,
  input  logic               recebe,
  output logic [N_DADOS-1:0] dados_ascii,
  output logic               pronto,
  output logic               tem_dado,
  output logic               erro_paridade,
  output logic               erro_stop
`ifdef RX_DEBUG_EN
  ,
  output logic [3:0]         db_estado,
  output logic               db_rx_s
`endif
);

  logic                  rx_meta;
  logic                  rx_s;
  logic [CNT_W-1:0]      contagem;
  logic [N_AMOSTRAS-1:0] palavra;
  logic                  bit_stop;
  logic                  zera_cnt;
  logic                  desloca;
  logic                  amostra_stop;
  logic                  carrega;
  estado_t               estado;

  rx_serial_7o1_uc #(
    .BAUD_DIV(BAUD_DIV),
    .CNT_W   (CNT_W)
  ) u_uc (
    .clock       (clock),
    .reset       (reset),
    .rx_s        (rx_s),
    .contagem    (contagem),
    .zera_cnt    (zera_cnt),
    .desloca     (desloca),
    .amostra_stop(amostra_stop),
    .estado      (estado)
  );

  assign carrega = (estado == FINAL);
  assign pronto  = carrega;

`ifdef RX_DEBUG_EN
  assign db_estado = estado;
  assign db_rx_s   = rx_s;
`endif

  // Two-flop synchronizer, preset to the idle level so reset looks like an idle line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= dado_serial;
      rx_s    <= rx_meta;
    end
  end

  // Bit-period counter, cleared by the control unit at each phase boundary
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera_cnt) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + CNT_W'(1);
    end
  end

  // Right-shifting sample register: the first bit received ends at bit 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      palavra <= '0;
    end else if (desloca) begin
      palavra <= {rx_s, palavra[N_AMOSTRAS-1:1]};
    end
  end

  // Stop bit captured at mid-bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_stop <= 1'b1;
    end else if (amostra_stop) begin
      bit_stop <= rx_s;
    end
  end

  // Delivered word and error flags, refreshed once per completed frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_ascii   <= '0;
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
    end else if (carrega) begin
      dados_ascii   <= palavra[N_DADOS-1:0];
      erro_paridade <= erro_paridade_impar(palavra);
      erro_stop     <= ~bit_stop;
    end
  end

  // Unread-word flag: a completing frame beats a simultaneous acknowledge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tem_dado <= 1'b0;
    end else if (carrega) begin
      tem_dado <= 1'b1;
    end else if (recebe) begin
      tem_dado <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Self-checking bench for rx_serial_7o1 with BAUD_DIV=8. Frames are driven
// on the serial line; the expected word/flags are pushed to a scoreboard and
// a monitor compares them whenever the receiver pulses pronto.
module tb_rx_serial_7o1;

  localparam int BAUD_DIV = 8;
  localparam int CNT_W    = 4;

  typedef struct {
    logic [6:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       dado_serial;
  logic       recebe;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_stop;
`ifdef RX_DEBUG_EN
  logic [3:0] db_estado;
  logic       db_rx_s;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  logic model_tem_dado;
  exp_t mon_e;

  rx_serial_7o1 #(
    .BAUD_DIV(BAUD_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dado_serial  (dado_serial),
    .recebe       (recebe),
    .dados_ascii  (dados_ascii),
    .pronto       (pronto),
    .tem_dado     (tem_dado),
    .erro_paridade(erro_paridade),
    .erro_stop    (erro_stop)
`ifdef RX_DEBUG_EN
    ,
    .db_estado    (db_estado),
    .db_rx_s      (db_rx_s)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string nome, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, actual, expected, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Parity bit that makes the count of ones over data+parity odd
  function automatic logic odd_par(input logic [6:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Drives one frame on the line, each bit held for a full bit period
  task automatic drive_frame(input logic [6:0] d, input logic par, input logic stp);
    dado_serial = 1'b0;
    wait_cycles(BAUD_DIV);
    for (int i = 0; i < 7; i++) begin
      dado_serial = d[i];
      wait_cycles(BAUD_DIV);
    end
    dado_serial = par;
    wait_cycles(BAUD_DIV);
    dado_serial = stp;
    wait_cycles(BAUD_DIV);
    dado_serial = 1'b1;
  endtask

  // Reference model: the word is the data field, parity error when the total
  // count of ones is even, framing error when the stop bit is low
  task automatic applyStimulus(input logic [6:0] d, input logic par, input logic stp);
    exp_t e;
    e.data = d;
    e.perr = (($countones(d) + int'(par)) % 2 == 0);
    e.serr = ~stp;
    sb_q.push_back(e);
    last_exp       = e;
    model_tem_dado = 1'b1;
    drive_frame(d, par, stp);
  endtask

  // Monitor: on each pronto pulse, check it is one cycle wide and compare
  // the delivered word and flags against the oldest expected frame
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && pronto === 1'b1) begin
        @(negedge clock);
        checkOutput("pronto_width", 8'(pronto), 8'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_pronto: got pronto, expected none at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("dados_ascii", 8'(dados_ascii), 8'(mon_e.data));
          checkOutput("erro_paridade", 8'(erro_paridade), 8'(mon_e.perr));
          checkOutput("erro_stop", 8'(erro_stop), 8'(mon_e.serr));
          checkOutput("tem_dado_set", 8'(tem_dado), 8'd1);
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         gap;
    logic [6:0] d;
    logic       par;
    logic       stp;

    reset          = 1'b0;
    dado_serial    = 1'b1;
    recebe         = 1'b0;
    model_tem_dado = 1'b0;
    last_exp       = '{data: 7'h00, perr: 1'b0, serr: 1'b0};
    wait_cycles(3);

    $display("[TB] reset state");
    checkOutput("rst_dados", 8'(dados_ascii), 8'h00);
    checkOutput("rst_pronto", 8'(pronto), 8'h00);
    checkOutput("rst_tem_dado", 8'(tem_dado), 8'h00);
    checkOutput("rst_erro_par", 8'(erro_paridade), 8'h00);
    checkOutput("rst_erro_stop", 8'(erro_stop), 8'h00);
    reset = 1'b1;
    wait_cycles(2 * BAUD_DIV);

    $display("[TB] frame 0x41 good parity");
    applyStimulus(7'h41, 1'b1, 1'b1);
    wait_cycles(2 * BAUD_DIV);

    $display("[TB] frame 0x41 bad parity");
    applyStimulus(7'h41, 1'b0, 1'b1);
    wait_cycles(2 * BAUD_DIV);

    $display("[TB] 2-cycle glitch on idle line");
    dado_serial = 1'b0;
    wait_cycles(2);
    dado_serial = 1'b1;
    wait_cycles(BAUD_DIV + 4);
    checkOutput("glitch_dados", 8'(dados_ascii), 8'(last_exp.data));
    checkOutput("glitch_erro_par", 8'(erro_paridade), 8'(last_exp.perr));
    checkOutput("glitch_tem_dado", 8'(tem_dado), 8'(model_tem_dado));

    $display("[TB] frame 0x7F with low stop bit");
    applyStimulus(7'h7F, 1'b0, 1'b0);
    wait_cycles(2 * BAUD_DIV);

    $display("[TB] line low for a whole frame");
    applyStimulus(7'h00, 1'b0, 1'b0);
    wait_cycles(2 * BAUD_DIV);

    $display("[TB] back-to-back 0x30 then 0x55");
    applyStimulus(7'h30, odd_par(7'h30), 1'b1);
    applyStimulus(7'h55, odd_par(7'h55), 1'b1);
    wait_cycles(2 * BAUD_DIV);
    checkOutput("b2b_dados", 8'(dados_ascii), 8'h55);
    checkOutput("b2b_tem_dado", 8'(tem_dado), 8'(model_tem_dado));
    recebe = 1'b1;
    wait_cycles(1);
    recebe         = 1'b0;
    model_tem_dado = 1'b0;
    checkOutput("ack_tem_dado", 8'(tem_dado), 8'(model_tem_dado));
    checkOutput("ack_keeps_dados", 8'(dados_ascii), 8'h55);

    $display("[TB] reset during reception of 0x41");
    dado_serial = 1'b0;
    wait_cycles(BAUD_DIV);
    dado_serial = 1'b1;
    wait_cycles(BAUD_DIV);
    dado_serial = 1'b0;
    wait_cycles(2 * BAUD_DIV);
    reset = 1'b0;
    #1;
    checkOutput("midrst_dados", 8'(dados_ascii), 8'h00);
    checkOutput("midrst_pronto", 8'(pronto), 8'h00);
    checkOutput("midrst_tem_dado", 8'(tem_dado), 8'h00);
    checkOutput("midrst_erro_par", 8'(erro_paridade), 8'h00);
    checkOutput("midrst_erro_stop", 8'(erro_stop), 8'h00);
    model_tem_dado = 1'b0;
    dado_serial    = 1'b1;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2 * BAUD_DIV);
    applyStimulus(7'h2A, odd_par(7'h2A), 1'b1);
    wait_cycles(2 * BAUD_DIV);

    $display("[TB] randomized frames");
    for (int n = 0; n < 12; n++) begin
      d   = 7'($urandom_range(0, 127));
      par = odd_par(d);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      applyStimulus(d, par, stp);
      gap = $urandom_range(0, 2 * BAUD_DIV);
      if (!stp && gap < BAUD_DIV) gap = BAUD_DIV;
      wait_cycles(gap);
    end
    wait_cycles(3 * BAUD_DIV);

    checkOutput("scoreboard_drain", 8'(sb_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7o1

Overview:
Serial receiver for 7O1 asynchronous frames: 1 start bit, 7 data bits sent LSB first, 1 odd-parity bit, 1 stop bit. It sits directly downstream of the serial transmitter and consumes its serial output line. Each frame is sampled at mid-bit, reassembled into a 7-bit ASCII word, and presented with a ready/acknowledge handshake plus error flags.

Parameters:
BAUD_DIV, 434, clock cycles per bit period (434 gives 50 MHz / 115200 baud); must be ≥4 and even.
CNT_W, 9, width of the bit-period counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
dado_serial  in  1  serial line; idles high.
recebe  in  1  consumer acknowledge; clears tem_dado.
dados_ascii  out  7  last received data word.
pronto  out  1  one-cycle pulse when a frame completes.
tem_dado  out  1  level signal: unread word held.
erro_paridade  out  1  parity mismatch on the last frame.
erro_stop  out  1  stop bit sampled low on the last frame.

Behaviour:
- Reset, asynchronous while reset=0: the state machine goes to INICIAL. All outputs are 0 (dados_ascii=0). The synchronizer flops are preset to 1.
- dado_serial passes through a 2-flop synchronizer. All decisions use the synchronized value (rx_s).
- States:
  - INICIAL: wait for rx_s=0, then go to START and clear the counter.
  - START: count BAUD_DIV/2 cycles. If rx_s=1 at that point, it is a false start: return to INICIAL. Otherwise clear the counter and the bit index, then go to RECEBE.
  - RECEBE: each time the counter reaches BAUD_DIV-1, sample rx_s into a shift register (right shift, so the first bit lands at bit 0 after 8 shifts) and increment the bit index. After 8 samples (7 data + parity), go to STOP.
  - STOP: after BAUD_DIV cycles, sample the stop bit, then go to FINAL.
  - FINAL: one cycle. Then return to INICIAL.
- In FINAL:
  - dados_ascii <= data bits.
  - erro_paridade <= ~(^{data,parity}); odd parity means the XOR of all 8 bits must be 1.
  - erro_stop <= ~stop_sample.
  - pronto=1 for exactly this cycle.
  - tem_dado <= 1.
- Data and flags are delivered even when an error is flagged. The registered outputs are stable until the next FINAL.
- Latency: take the cycle rx_s is first seen low in INICIAL as cycle 0. The start check is at cycle BAUD_DIV/2. Bit k (k=0..7) is sampled at BAUD_DIV/2 + (k+1)·BAUD_DIV. The stop bit is sampled at BAUD_DIV/2 + 9·BAUD_DIV. pronto is asserted the cycle after the stop sample.
- Handshake: recebe=1 clears tem_dado on the next edge. If recebe=1 and FINAL occur in the same cycle, FINAL wins and tem_dado=1. When a new frame completes with tem_dado already 1, the new data overwrites the old (no overrun flag).
- The next start bit is accepted from INICIAL in the cycle after FINAL, so back-to-back frames with exactly one stop bit are received.
- A line held low forever: a framing error is reported (erro_stop=1). The machine then re-enters START immediately from INICIAL.
- recebe and dado_serial are ignored while reset=0.

Optional Feature:
RX_DEBUG_EN.
- Defined: adds an output port db_estado [3:0] carrying the current state encoding (INICIAL=0, START=1, RECEBE=2, STOP=3, FINAL=4), plus an output db_rx_s mirroring rx_s.
- Undefined: these ports do not exist; behaviour is otherwise identical.

Decomposition:
- Package rx_serial_pkg holds:
  - the state enum and its 4-bit encodings;
  - N_DADOS=7 and N_AMOSTRAS=8;
  - the parity-check function.
- One natural sub-module: rx_serial_7o1_uc (control unit: state machine, bit index, counter compare, tick decode).
- The top level holds the datapath: synchronizer, counter, shift register, output registers.

Test Plan:
All scenarios use BAUD_DIV=8.
1. Frame for 0x41: bits 1,0,0,0,0,0,1, parity 1, stop 1 -> one pronto pulse; dados_ascii=0x41; erro_paridade=0; erro_stop=0; tem_dado=1.
2. Same frame with parity 0 -> dados_ascii=0x41, erro_paridade=1, erro_stop=0, pronto pulses once.
3. Low glitch of 2 cycles on an idle line -> machine returns to INICIAL by cycle BAUD_DIV/2+1; no pronto; outputs unchanged.
4. Frame for 0x7F (parity 0) with stop bit 0 -> dados_ascii=0x7F, erro_stop=1, erro_paridade=0.
5. Two back-to-back frames, 0x30 then 0x55, with no recebe between them -> two pronto pulses; final dados_ascii=0x55; tem_dado=1. Then recebe=1 for one cycle -> tem_dado=0.
6. reset=0 asserted mid-RECEBE of frame 0x41 -> all outputs 0 immediately. After release on an idle line, a new frame 0x2A is received correctly.
